// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter onto a byte-wide synchronous RAM bus.
// Optional macro MEM_ARB_RR_EN: round-robin tie-break instead of fixed MEM priority.
module mem_arbiter #(
   parameter  int ADDR_WIDTH = 32,
   parameter  int WORD_BYTES = 4,
   localparam int LEN_W      = $clog2(WORD_BYTES),
   localparam int DW         = 8 * WORD_BYTES
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rdy,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic [DW-1:0]         if_rdata,
   output logic                  if_done,
   input  logic                  mem_req,
   input  logic                  mem_rw,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [LEN_W-1:0]      mem_len,
   input  logic [DW-1:0]         mem_wdata,
   output logic [DW-1:0]         mem_rdata,
   output logic                  mem_done,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [7:0]            ram_dout,
   output logic                  ram_wr,
   input  logic [7:0]            ram_din,
   output logic                  busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      XFER  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t            state, state_nx;
   logic [LEN_W-1:0]  k;
   logic [LEN_W-1:0]  len_q;
   logic              rw_q;
   logic              gnt_mem_q;
   logic [DW-1:0]     wdata_q;
   logic [DW-1:0]     buf_q, buf_nx;
   logic              any_req;
   logic              pick_mem;
   logic              cap_en;
   logic [LEN_W-1:0]  cap_lane;

   assign any_req = if_req | mem_req;

`ifdef MEM_ARB_RR_EN
   // Set when IF won the last grant, so the next tie goes to MEM.
   logic last_if;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_if <= 1'b1;
      end else if (rdy && state == IDLE && any_req) begin
         last_if <= ~pick_mem;
      end
   end
   assign pick_mem = mem_req & (~if_req | last_if);
`else
   assign pick_mem = mem_req;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      if (rdy) begin
         case (state)
            IDLE:    if (any_req) state_nx = XFER;
            XFER:    if (k == len_q) state_nx = rw_q ? DONE : DRAIN;
            DRAIN:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
      end
   end

   // RAM read data lags the address by one cycle, so lane k-1 lands while k is on the bus.
   always_comb begin
      cap_en   = ~rw_q && ((state == XFER && k != '0) || state == DRAIN);
      cap_lane = (state == DRAIN) ? len_q : k - LEN_W'(1);
      buf_nx   = buf_q;
      for (int i = 0; i < WORD_BYTES; i++) begin
         if (cap_en && cap_lane == LEN_W'(i)) begin
            buf_nx[8*i +: 8] = ram_din;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k         <= '0;
         len_q     <= '0;
         rw_q      <= 1'b0;
         gnt_mem_q <= 1'b0;
         wdata_q   <= '0;
         buf_q     <= '0;
         ram_addr  <= '0;
         if_rdata  <= '0;
         mem_rdata <= '0;
      end else if (rdy) begin
         buf_q <= buf_nx;
         case (state)
            IDLE: begin
               if (any_req) begin
                  gnt_mem_q <= pick_mem;
                  k         <= '0;
                  buf_q     <= '0;
                  if (pick_mem) begin
                     ram_addr <= mem_addr;
                     rw_q     <= mem_rw;
                     len_q    <= mem_len;
                     wdata_q  <= mem_wdata;
                  end else begin
                     ram_addr <= if_addr;
                     rw_q     <= 1'b0;
                     len_q    <= LEN_W'(WORD_BYTES - 1);
                     wdata_q  <= '0;
                  end
               end
            end
            XFER: begin
               if (k != len_q) begin
                  k        <= k + LEN_W'(1);
                  ram_addr <= ram_addr + ADDR_WIDTH'(1);
               end
            end
            DRAIN: begin
               if (gnt_mem_q) mem_rdata <= buf_nx;
               else           if_rdata  <= buf_nx;
            end
            default: ;
         endcase
      end
   end

   assign ram_wr   = rdy && state == XFER && rw_q;
   assign ram_dout = (state == XFER && rw_q) ? wdata_q[8*k +: 8] : 8'h00;
   assign if_done  = (state == DONE) && ~gnt_mem_q;
   assign mem_done = (state == DONE) && gnt_mem_q;
   assign busy     = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reads, writes, address wrap, arbitration, stall and reset abort.
module tb_mem_arbiter;

   localparam int AW = 32;
   localparam int WB = 4;
   localparam int DW = 8 * WB;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          rdy;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic [DW-1:0] if_rdata;
   logic          if_done;
   logic          mem_req;
   logic          mem_rw;
   logic [AW-1:0] mem_addr;
   logic [1:0]    mem_len;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_done;
   logic [AW-1:0] ram_addr;
   logic [7:0]    ram_dout;
   logic          ram_wr;
   logic [7:0]    ram_din = 8'h00;
   logic          busy;

   int checks = 0;
   int errors = 0;

   logic [AW-1:0] addr_log [0:63];
   logic          wr_log   [0:63];
   logic [7:0]    dout_log [0:63];
   logic [7:0]    ram      [0:4095];

   mem_arbiter #(.ADDR_WIDTH(AW), .WORD_BYTES(WB)) dut (
      .clk(clk), .rst_n(rst_n), .rdy(rdy),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
      .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_len(mem_len),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
      .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_wr(ram_wr), .ram_din(ram_din),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // RAM model shares the global run enable, so its read data holds during a stall.
   always @(posedge clk) begin
      if (rdy) begin
         if (ram_wr) ram[ram_addr[11:0]] <= ram_dout;
         ram_din <= ram[ram_addr[11:0]];
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Log bus activity from cycle 'start' until the chosen done pulse; lat=0 on timeout.
   task automatic wait_done(input bit want_mem, input int start, output int lat);
      lat = 0;
      for (int c = start; c < start + 40; c++) begin
         addr_log[c] = ram_addr;
         wr_log[c]   = ram_wr;
         dout_log[c] = ram_dout;
         if ((want_mem ? mem_done : if_done) === 1'b1) begin
            lat = c;
            break;
         end
         tick();
      end
   endtask

   task automatic wait_any(output int who, output int lat);
      who = 0;
      lat = 0;
      for (int c = 1; c < 40; c++) begin
         if (mem_done === 1'b1) begin who = 1; lat = c; break; end
         if (if_done === 1'b1)  begin who = 2; lat = c; break; end
         tick();
      end
   endtask

   int lat;
   int who;
   int exp_who [0:2];

   initial begin
      rst_n = 1'b0; rdy = 1'b1;
      if_req = 1'b0; if_addr = '0;
      mem_req = 1'b0; mem_rw = 1'b0; mem_addr = '0; mem_len = '0; mem_wdata = '0;
      for (int i = 0; i < 4096; i++) ram[i] = 8'h5A;
      ram[12'h100] = 8'h11; ram[12'h101] = 8'h22; ram[12'h102] = 8'h33; ram[12'h103] = 8'h44;
      ram[12'hFFF] = 8'h77; ram[12'h000] = 8'h81; ram[12'h001] = 8'h92; ram[12'h002] = 8'hA3;
      ram[12'h140] = 8'h01; ram[12'h141] = 8'h02; ram[12'h142] = 8'h03; ram[12'h143] = 8'h04;

      // Reset state
      tick(); tick();
      chk("rst_busy", busy, 0);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_ram_wr", ram_wr, 0);
      chk("rst_ram_dout", ram_dout, 0);
      chk("rst_dones", {if_done, mem_done}, 0);
      chk("rst_rdata", {if_rdata, mem_rdata}, 0);
      rst_n = 1'b1;
      tick();

      // IF read of four bytes at 0x100
      if_req = 1'b1; if_addr = 32'h100;
      tick();
      if_req = 1'b0;
      chk("if_busy", busy, 1);
      wait_done(1'b0, 1, lat);
      chk("if_lat", lat, 6);
      for (int c = 1; c <= 4; c++) chk("if_addr_seq", addr_log[c], 32'h100 + c - 1);
      chk("if_no_wr", {wr_log[1], wr_log[2], wr_log[3], wr_log[4], wr_log[5]}, 0);
      chk("if_rdata", if_rdata, 32'h44332211);
      chk("if_mem_done_quiet", mem_done, 0);
      tick();
      chk("if_done_one_cycle", if_done, 0);
      chk("if_idle", busy, 0);

      // MEM write of two bytes at 0x20
      mem_req = 1'b1; mem_rw = 1'b1; mem_addr = 32'h20; mem_len = 2'd1; mem_wdata = 32'hAABBCCDD;
      tick();
      mem_req = 1'b0;
      wait_done(1'b1, 1, lat);
      chk("wr_lat", lat, 3);
      chk("wr_c1", {wr_log[1], addr_log[1], dout_log[1]}, {1'b1, 32'h20, 8'hDD});
      chk("wr_c2", {wr_log[2], addr_log[2], dout_log[2]}, {1'b1, 32'h21, 8'hCC});
      chk("wr_c3_off", wr_log[3], 0);
      tick();
      chk("wr_ram", {ram[12'h20], ram[12'h21], ram[12'h22]}, {8'hDD, 8'hCC, 8'h5A});
      chk("wr_rdata_held", mem_rdata, 0);
      chk("wr_done_one_cycle", mem_done, 0);

      // MEM single-byte read at the top of the address space
      mem_req = 1'b1; mem_rw = 1'b0; mem_addr = 32'hFFFFFFFF; mem_len = 2'd0;
      tick();
      mem_req = 1'b0;
      wait_done(1'b1, 1, lat);
      chk("rd1_lat", lat, 3);
      chk("rd1_addr", addr_log[1], 32'hFFFFFFFF);
      chk("rd1_rdata", mem_rdata, 32'h00000077);
      tick();

      // Four-byte read from the same address wraps through zero
      mem_req = 1'b1; mem_len = 2'd3;
      tick();
      mem_req = 1'b0;
      wait_done(1'b1, 1, lat);
      chk("rd4_lat", lat, 6);
      chk("rd4_addr0", addr_log[1], 32'hFFFFFFFF);
      chk("rd4_addr1", addr_log[2], 32'h0);
      chk("rd4_addr2", addr_log[3], 32'h1);
      chk("rd4_addr3", addr_log[4], 32'h2);
      chk("rd4_rdata", mem_rdata, 32'hA3928177);
      chk("rd4_if_rdata_held", if_rdata, 32'h44332211);
      tick();

      // IF read stalled for three cycles while k=2
      if_req = 1'b1; if_addr = 32'h140;
      tick();
      if_req = 1'b0;
      tick();
      tick();
      chk("stall_addr_k2", ram_addr, 32'h142);
      rdy = 1'b0;
      tick();
      chk("stall_hold1", {ram_addr, ram_wr, busy}, {32'h142, 1'b0, 1'b1});
      tick();
      chk("stall_hold2", {ram_addr, ram_wr, if_done}, {32'h142, 1'b0, 1'b0});
      tick();
      chk("stall_hold3", {ram_addr, ram_wr, if_done}, {32'h142, 1'b0, 1'b0});
      rdy = 1'b1;
      wait_done(1'b0, 6, lat);
      chk("stall_lat", lat, 9);
      chk("stall_rdata", if_rdata, 32'h04030201);
      tick();

      // Reset during a four-byte write at k=1
      mem_req = 1'b1; mem_rw = 1'b1; mem_addr = 32'h400; mem_len = 2'd3; mem_wdata = 32'h12345678;
      tick();
      mem_req = 1'b0;
      tick();
      chk("abort_pre_wr", {ram_wr, ram_addr, ram_dout}, {1'b1, 32'h401, 8'h56});
      #2 rst_n = 1'b0;
      #1;
      chk("abort_wr_off", ram_wr, 0);
      chk("abort_busy", busy, 0);
      chk("abort_regs", {ram_addr, ram_dout, if_rdata, mem_rdata}, 0);
      tick();
      chk("abort_no_done", {mem_done, if_done, busy}, 0);
      tick();
      chk("abort_ram", {ram[12'h400], ram[12'h401]}, {8'h78, 8'h5A});

      // Both ports held for three transfers straight out of reset
      rst_n = 1'b1;
      if_req = 1'b1; if_addr = 32'h200;
      mem_req = 1'b1; mem_rw = 1'b0; mem_addr = 32'h100; mem_len = 2'd0;
`ifdef MEM_ARB_RR_EN
      exp_who[0] = 1; exp_who[1] = 2; exp_who[2] = 1;
`else
      exp_who[0] = 1; exp_who[1] = 1; exp_who[2] = 1;
`endif
      for (int t = 0; t < 3; t++) begin
         tick();
         chk("arb_grant_busy", busy, 1);
         if (t == 2) begin
            if_req = 1'b0;
            mem_req = 1'b0;
         end
         wait_any(who, lat);
         chk("arb_winner", who, exp_who[t]);
         chk("arb_lat", lat, (exp_who[t] == 1) ? 3 : 6);
         tick();
         chk("arb_gap_idle", busy, 0);
      end
      tick();
      chk("arb_final_idle", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, byte-address width of the RAM bus and both request ports.
REQ-002 The block SHALL have parameter WORD_BYTES, default 4, a power of two ≥2, giving the maximum transfer length in bytes; LEN_W = clog2(WORD_BYTES).
REQ-003 The block SHALL have ports clk in 1 (system clock) and rst_n in 1 (reset, asynchronous, active-low), then:
- rdy in 1: global run enable.
- if_req in 1; if_addr in ADDR_WIDTH: instruction-fetch request and base address.
- if_rdata out 8*WORD_BYTES; if_done out 1: fetched word and completion pulse.
- mem_req in 1; mem_rw in 1 (1 write, 0 read); mem_addr in ADDR_WIDTH; mem_len in LEN_W (byte count minus 1); mem_wdata in 8*WORD_BYTES: data-port request.
- mem_rdata out 8*WORD_BYTES; mem_done out 1: data-port read data and completion pulse.
- ram_addr out ADDR_WIDTH; ram_dout out 8; ram_wr out 1; ram_din in 8: byte-wide RAM bus, read data valid one cycle after address.
- busy out 1: high whenever state is not IDLE.

Function
REQ-004 The FSM SHALL have states IDLE, XFER, DRAIN and DONE.
REQ-005 In IDLE with any request high at a clock edge, the FSM SHALL latch the winner's address, rw, length and wdata, clear counter k, and enter XFER.
REQ-006 IF transfers SHALL be reads of WORD_BYTES bytes; MEM transfers SHALL move mem_len+1 bytes.
REQ-007 In XFER, ram_addr SHALL equal base+k modulo 2^ADDR_WIDTH, with k incrementing each active cycle from 0 to N-1.
REQ-008 During a write XFER, ram_wr SHALL be 1 and ram_dout SHALL carry byte lane k (bits 8k+7:8k) of the latched wdata; after k=N-1 the FSM SHALL go to DONE.
REQ-009 During a read XFER, ram_wr SHALL be 0, and byte lane k of the result SHALL be written from ram_din in the cycle after address k (little-endian).
REQ-010 After the last read address, the FSM SHALL spend one cycle in DRAIN capturing byte N-1, then go to DONE.
REQ-011 Read lanes ≥N SHALL be zero.
REQ-012 In DONE, the granted port's done SHALL be high for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-013 if_rdata and mem_rdata SHALL update only at that port's DONE and hold until its next read DONE.
REQ-014 Read latency SHALL be N+2 cycles from the grant edge to done; write latency SHALL be N+1 cycles.
REQ-015 Requests SHALL be ignored outside IDLE; a request dropped mid-transfer SHALL still complete and pulse done.
REQ-016 A request still high in the cycle after DONE SHALL be re-arbitrated as a new request.
REQ-017 When both requests are high in IDLE, the arbitration rule of REQ-022 SHALL apply.
REQ-018 While rdy=0, all state, counter and capture registers SHALL hold, and ram_wr SHALL be forced to 0. A capture pending at the rdy fall SHALL occur on the first cycle with rdy=1, since ram_addr is held.
REQ-019 In IDLE, ram_wr SHALL be 0 and ram_addr SHALL hold its last value.

Reset
REQ-020 While rst_n=0, regardless of clk, the block SHALL force: state IDLE, k=0, ram_addr=0, ram_dout=0, ram_wr=0, if_done=0, mem_done=0, if_rdata=0, mem_rdata=0, busy=0, RR pointer favouring MEM.
REQ-021 A reset asserted mid-transfer SHALL abort it with no done pulse; the first grant SHALL occur on the first edge after rst_n rises with a request present.

Configuration
REQ-022 Without macro MEM_ARB_RR_EN, MEM SHALL have fixed priority over IF. With MEM_ARB_RR_EN defined, ties SHALL go to the port not granted most recently, with the pointer updated at each grant; non-tie grants SHALL be unchanged.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- IF read, if_addr=0x100, RAM bytes 11,22,33,44 -> ram_addr 0x100..0x103, if_rdata=0x44332211, if_done 1 cycle, 6 cycles after grant.
- MEM write, mem_len=1, mem_addr=0x20, mem_wdata=0xAABBCCDD -> ram_wr=1 for two cycles, writes 0xDD@0x20 and 0xCC@0x21, mem_done at grant+3.
- MEM read, mem_len=0, mem_addr=0xFFFFFFFF, ADDR_WIDTH=32 -> single address 0xFFFFFFFF, mem_rdata=0x000000xx; mem_len=3 at the same address -> addresses wrap to 0,1,2.
- if_req and mem_req held high for 3 transfers -> without macro: MEM,MEM,MEM; with MEM_ARB_RR_EN: MEM,IF,MEM.
- rdy low 3 cycles mid-read at k=2 -> no ram_wr, address held, final if_rdata correct, latency +3.
- rst_n low during write at k=1 -> ram_wr=0 immediately, no mem_done, busy=0.
